// File: rtl/button_conditioner.sv
// Button front end: three raw push-buttons (start, stop, reset) become
// clean single-cycle command pulses. Each button goes through a 2-flop
// synchronizer, a counter-based debouncer and a rising-edge detector.
// A registered priority stage then keeps the command pulses mutually exclusive.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start_raw,
   input  logic       btn_stop_raw,
   input  logic       btn_reset_raw,
   output logic       start,
   output logic       stop,
   output logic       sync_reset,
   output logic [2:0] btn_level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Bit order everywhere: {reset, stop, start}
   logic [2:0]       raw;
   logic [2:0]       sync_meta;
   logic [2:0]       sync;
   logic [2:0]       db;
   logic [2:0]       db_d;
   logic [2:0]       raw_pulse;
   logic [CNT_W-1:0] cnt [3];

   logic next_start;
   logic next_stop;
   logic next_sync_reset;

   assign raw       = {btn_reset_raw, btn_stop_raw, btn_start_raw};
   assign raw_pulse = db & ~db_d;
   assign btn_level = db;

   // Two-flop synchronizer for the asynchronous button inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= raw;
         sync      <= sync_meta;
      end
   end

   // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive
   // mismatching samples; any matching sample restarts the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db <= '0;
         for (int unsigned i = 0; i < 3; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            if (sync[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               db[i]  <= sync[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Edge-history register for press detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_d <= '0;
      end else begin
         db_d <= db;
      end
   end

   // Priority: reset beats stop, stop beats start; losers are dropped
   always_comb begin
      next_start      = 1'b0;
      next_stop       = 1'b0;
      next_sync_reset = 1'b0;
      if (raw_pulse[2]) begin
         next_sync_reset = 1'b1;
      end else if (raw_pulse[1]) begin
         next_stop = 1'b1;
      end else begin
         next_start = raw_pulse[0];
      end
   end

   // Registered command outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start      <= 1'b0;
         stop       <= 1'b0;
         sync_reset <= 1'b0;
      end else begin
         start      <= next_start;
         stop       <= next_stop;
         sync_reset <= next_sync_reset;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus a
// random bounce soak, compared every cycle against a sliding-window model.
module tb_button_conditioner;

   localparam int DC = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       b_start = 1'b0;
   logic       b_stop = 1'b0;
   logic       b_reset = 1'b0;
   logic       start;
   logic       stop;
   logic       sync_reset;
   logic [2:0] btn_level;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model state: sample history per button (bit 0 = newest), debounced levels
   bit [63:0] hist [3];
   bit [2:0]  mdb = '0;
   bit [2:0]  mdb_d = '0;
   bit        exp_start = 0, exp_stop = 0, exp_sr = 0;
   bit [2:0]  exp_level = '0;
   int        m_start_cnt = 0, m_stop_cnt = 0, m_sr_cnt = 0;
   int        m_start_edge = -1;

   // DUT observation bookkeeping
   int   d_start_cnt = 0, d_stop_cnt = 0, d_sr_cnt = 0;
   int   d_start_edge = -1, d_stop_edge = -1, lvl0_edge = -1;
   logic p_start = 0, p_stop = 0, p_sr = 0;
   logic [2:0] p_level = '0;

   button_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_start_raw(b_start),
      .btn_stop_raw (b_stop),
      .btn_reset_raw(b_reset),
      .start        (start),
      .stop         (stop),
      .sync_reset   (sync_reset),
      .btn_level    (btn_level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Reference model: a button's debounced level flips when the last DC
   // synchronized samples (raw delayed two edges) all disagree with it.
   initial begin
      bit [2:0] rise;
      bit [2:0] rawv;
      bit       allmis;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < 3; i++) hist[i] = '0;
            mdb = '0; mdb_d = '0;
            exp_start = 0; exp_stop = 0; exp_sr = 0; exp_level = '0;
         end else begin
            rise = mdb & ~mdb_d;
            exp_sr    = rise[2];
            exp_stop  = !rise[2] && rise[1];
            exp_start = !rise[2] && !rise[1] && rise[0];
            if (exp_start) begin m_start_cnt++; m_start_edge = cyc + 1; end
            if (exp_stop) m_stop_cnt++;
            if (exp_sr) m_sr_cnt++;
            rawv = {b_reset, b_stop, b_start};
            mdb_d = mdb;
            for (int i = 0; i < 3; i++) begin
               hist[i] = {hist[i][62:0], rawv[i]};
               allmis = 1;
               for (int j = 2; j <= DC + 1; j++)
                  if (hist[i][j] == mdb[i]) allmis = 0;
               if (allmis) mdb[i] = ~mdb[i];
            end
            exp_level = mdb;
         end
      end
   end

   // Compare process: every cycle, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         check("start", int'(start), int'(exp_start));
         check("stop", int'(stop), int'(exp_stop));
         check("sync_reset", int'(sync_reset), int'(exp_sr));
         check("btn_level", int'(btn_level), int'(exp_level));
         check("exclusive", int'($countones({start, stop, sync_reset}) <= 1), 1);
         check("width", int'((start & p_start) | (stop & p_stop) | (sync_reset & p_sr)), 0);
         if (start) begin d_start_cnt++; d_start_edge = cyc; end
         if (stop) begin d_stop_cnt++; d_stop_edge = cyc; end
         if (sync_reset) d_sr_cnt++;
         if (btn_level[0] && !p_level[0]) lvl0_edge = cyc;
         p_start = start; p_stop = stop; p_sr = sync_reset; p_level = btn_level;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, f0, cs, cp, cr, ms, rate;
      tick(3);
      check("reset_outs", int'({start, stop, sync_reset}), 0);
      check("reset_level", int'(btn_level), 0);
      rst_n = 1'b1;
      tick(3);

      // Clean press
      cs = d_start_cnt; ms = m_start_cnt; cp = d_stop_cnt; cr = d_sr_cnt;
      b_start = 1'b1; e0 = cyc + 1;
      tick(20);
      check("clean_cnt", d_start_cnt - cs, 1);
      check("clean_mdl_cnt", m_start_cnt - ms, 1);
      check("clean_edge", d_start_edge, e0 + 6);
      check("clean_mdl_edge", m_start_edge, e0 + 6);
      check("clean_level_edge", lvl0_edge, e0 + 5);
      check("clean_others", (d_stop_cnt - cp) + (d_sr_cnt - cr), 0);
      b_start = 1'b0;
      tick(10);

      // Bounce rejection, then a real press
      cp = d_stop_cnt;
      b_stop = 1'b1; tick(3);
      b_stop = 1'b0; tick(1);
      b_stop = 1'b1; tick(3);
      b_stop = 1'b0; tick(8);
      check("bounce_cnt", d_stop_cnt - cp, 0);
      check("bounce_level", int'(btn_level[1]), 0);
      b_stop = 1'b1; tick(10);
      check("bounce_then_press", d_stop_cnt - cp, 1);
      b_stop = 1'b0; tick(10);

      // Release and re-press
      cs = d_start_cnt; ms = m_start_cnt;
      b_start = 1'b1; tick(10);
      b_start = 1'b0; tick(10);
      b_start = 1'b1; tick(10);
      b_start = 1'b0; tick(10);
      check("repress_cnt", d_start_cnt - cs, 2);
      check("repress_mdl_cnt", m_start_cnt - ms, 2);

      // Simultaneous start and stop: stop wins
      cs = d_start_cnt; cp = d_stop_cnt;
      b_start = 1'b1; b_stop = 1'b1; e0 = cyc + 1;
      tick(12);
      check("simul_start", d_start_cnt - cs, 0);
      check("simul_stop", d_stop_cnt - cp, 1);
      check("simul_stop_edge", d_stop_edge, e0 + 6);
      b_start = 1'b0; b_stop = 1'b0; tick(10);

      // All three together: only sync_reset
      cs = d_start_cnt; cp = d_stop_cnt; cr = d_sr_cnt;
      b_start = 1'b1; b_stop = 1'b1; b_reset = 1'b1;
      tick(12);
      check("all3_sr", d_sr_cnt - cr, 1);
      check("all3_others", (d_start_cnt - cs) + (d_stop_cnt - cp), 0);
      b_start = 1'b0; b_stop = 1'b0; b_reset = 1'b0; tick(10);

      // Async reset mid-debounce with the button still held
      cs = d_start_cnt;
      b_start = 1'b1; e0 = cyc + 1;
      tick(4);
      check("pre_rst_edge", cyc, e0 + 3);
      rst_n = 1'b0;
      #1;
      check("async_rst_outs", int'({start, stop, sync_reset}), 0);
      check("async_rst_level", int'(btn_level), 0);
      tick(2);
      rst_n = 1'b1; f0 = cyc + 1;
      tick(15);
      check("rst_hold_cnt", d_start_cnt - cs, 1);
      check("rst_hold_edge", d_start_edge, f0 + DC + 2);
      b_start = 1'b0; tick(10);

      // Random bounce soak
      rate = 4;
      for (int c = 0; c < 10000; c++) begin
         if (c % 500 == 0) rate = 1 << $urandom_range(1, 4);
         if ($urandom_range(0, rate - 1) == 0) b_start = ~b_start;
         if ($urandom_range(0, rate - 1) == 0) b_stop = ~b_stop;
         if ($urandom_range(0, rate - 1) == 0) b_reset = ~b_reset;
         if (c == 5000) rst_n = 1'b0;
         if (c == 5003) rst_n = 1'b1;
         tick(1);
      end
      b_start = 1'b0; b_stop = 1'b0; b_reset = 1'b0;
      tick(10);
      check("total_start", d_start_cnt, m_start_cnt);
      check("total_stop", d_stop_cnt, m_stop_cnt);
      check("total_sr", d_sr_cnt, m_sr_cnt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
